// File: rtl/psk_sched_pkg.sv
// Shared constants, config state encoding and the constellation-size legality check
// for the PSK demapper scheduler.
package psk_sched_pkg;

  localparam int unsigned DW_DEFAULT = 16;

  localparam logic [5:0] NP_4     = 6'd4;
  localparam logic [5:0] NP_8     = 6'd8;
  localparam logic [5:0] NP_12    = 6'd12;
  localparam logic [5:0] NP_16    = 6'd16;
  localparam logic [5:0] NP_RESET = NP_4;

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_t;

  function automatic logic np_legal(input logic [5:0] np);
    return (np == NP_4) || (np == NP_8) || (np == NP_12) || (np == NP_16);
  endfunction

endpackage

// File: rtl/psk_rr_arb.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward with wrap.
// gid_o carries the search result even when disabled (0 when nothing requests).
module psk_rr_arb #(
  parameter  int unsigned NCH = 4,
  localparam int unsigned CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic           en_i,
  input  logic [CW-1:0]  last_grant_i,
  output logic [NCH-1:0] grant_o,
  output logic [CW-1:0]  gid_o,
  output logic           any_o
);

  logic [CW:0] idx;
  logic        found;

  always_comb begin
    found = 1'b0;
    gid_o = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = {1'b0, last_grant_i} + (CW+1)'(i);
      if (idx >= (CW+1)'(NCH)) begin
        idx = idx - (CW+1)'(NCH);
      end
      if (!found && req_i[idx[CW-1:0]]) begin
        found = 1'b1;
        gid_o = idx[CW-1:0];
      end
    end
    any_o   = en_i && found;
    grant_o = any_o ? (NCH'(1) << gid_o) : '0;
  end

endmodule

// File: rtl/psk_demap_sched.sv
// Round-robin scheduler sharing one combinational PSK demapper between NCH requesters.
// Optional per-channel accept counters: define PSK_SCHED_STATS_EN.
module psk_demap_sched
  import psk_sched_pkg::*;
#(
  parameter  int unsigned NCH = 4,
  parameter  int unsigned DW  = DW_DEFAULT,
  localparam int unsigned CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_real,
  input  logic [NCH*DW-1:0] in_imag,
  input  logic              cfg_wr,
  input  logic [5:0]        cfg_n_points,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic [DW-1:0]     dm_x_real,
  output logic [DW-1:0]     dm_x_imag,
  output logic [5:0]        dm_n_points,
  input  logic [5:0]        dm_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_index,
  output logic [CW-1:0]     out_chan
`ifdef PSK_SCHED_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [NCH*32-1:0] stat_count
`endif
);

  logic [CW-1:0] last_grant_q, last_grant_d;
  logic          out_valid_q, out_valid_d;
  logic [5:0]    out_index_q, out_index_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  cfg_state_t    cfg_state_q, cfg_state_d;
  logic [5:0]    pend_val_q, pend_val_d;
  logic [5:0]    np_q, np_d;
  logic          cfg_err_q, cfg_err_d;

  logic           out_free;
  logic           accept_en;
  logic           accept;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  gid;
  logic [DW-1:0]  re_a [NCH];
  logic [DW-1:0]  im_a [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign re_a[c] = in_real[c*DW +: DW];
    assign im_a[c] = in_imag[c*DW +: DW];
  end

  assign out_free  = !out_valid_q || out_ready;
  assign accept_en = out_free && (cfg_state_q == CFG_IDLE) && !rst;

  psk_rr_arb #(.NCH(NCH)) u_arb (
    .req_i        (in_valid),
    .en_i         (accept_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .gid_o        (gid),
    .any_o        (accept)
  );

  assign in_ready    = grant;
  assign dm_x_real   = re_a[gid];
  assign dm_x_imag   = im_a[gid];
  assign dm_n_points = np_q;
  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign out_chan    = out_chan_q;
  assign cfg_busy    = (cfg_state_q == CFG_PEND);
  assign cfg_err     = cfg_err_q;

  always_comb begin
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_chan_d   = out_chan_q;
    cfg_state_d  = cfg_state_q;
    pend_val_d   = pend_val_q;
    np_d         = np_q;
    cfg_err_d    = 1'b0;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_index_d  = dm_index;
      out_chan_d   = gid;
      last_grant_d = gid;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    // Apply consumes the old pending value; a same-cycle write then re-arms pending.
    if ((cfg_state_q == CFG_PEND) && !out_valid_q) begin
      np_d        = pend_val_q;
      cfg_state_d = CFG_IDLE;
    end
    if (cfg_wr) begin
      if (np_legal(cfg_n_points)) begin
        pend_val_d  = cfg_n_points;
        cfg_state_d = CFG_PEND;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= CW'(NCH-1);
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_chan_q   <= '0;
      cfg_state_q  <= CFG_IDLE;
      pend_val_q   <= NP_RESET;
      np_q         <= NP_RESET;
      cfg_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_chan_q   <= out_chan_d;
      cfg_state_q  <= cfg_state_d;
      pend_val_q   <= pend_val_d;
      np_q         <= np_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

`ifdef PSK_SCHED_STATS_EN
  logic [31:0] stat_q [NCH];
  logic [31:0] stat_d [NCH];

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      stat_d[c] = stat_q[c];
      if (stat_clr) begin
        stat_d[c] = '0;
      end else if (grant[c] && (stat_q[c] != '1)) begin
        stat_d[c] = stat_q[c] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rst) begin
        stat_q[c] <= '0;
      end else begin
        stat_q[c] <= stat_d[c];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_stat
    assign stat_count[c*32 +: 32] = stat_q[c];
  end
`endif

endmodule

// File: doc/psk_demap_sched.md
# psk_demap_sched

Round-robin scheduler that shares one combinational PSK demapper (angle slicer producing a 6-bit constellation index) between NCH sample requesters. It arbitrates the I/Q input streams, drives the shared demapper, and registers each result with its channel tag behind a valid/ready output. It also owns the constellation-size configuration, which it applies only when the datapath is drained. It sits between the per-channel sample front ends and the symbol-to-bit unpacker.

## Interface
- NCH, 4: number of requesters (2..8); CW = $clog2(NCH) derived
- DW, 16: I/Q sample width (signed, Q8.8 as used by the demapper)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  NCH  per-channel sample valid
- in_ready  out  NCH  per-channel accept; at most one bit high per cycle
- in_real, in_imag  in  NCH*DW  packed samples, channel c at [c*DW +: DW]
- cfg_wr  in  1  one-cycle config write strobe
- cfg_n_points  in  6  requested constellation size
- cfg_busy  out  1  config write pending
- cfg_err  out  1  one-cycle pulse: rejected cfg_n_points
- dm_x_real, dm_x_imag  out  DW  to shared demapper (combinational mux of granted channel)
- dm_n_points  out  6  active constellation size
- dm_index  in  6  demapper result, combinational from dm_x_*
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_index  out  6  registered constellation index
- out_chan  out  CW  source channel of out_index

## Operation
- Output register (out_valid/out_index/out_chan) is a single entry. It is "free" when out_valid==0 or out_ready==1.
- Accept condition: register free AND no config pending. Under this condition the round-robin arbiter picks the first channel with in_valid set, searching from last_grant+1 upward with wrap. Only that channel's in_ready is asserted. in_ready is a function of in_valid; requesters must not make in_valid depend on in_ready.
- On accept: dm_x_* = granted channel's samples; dm_index, grant id → out_index/out_chan; out_valid←1; last_grant←grant.
- Free with no accept: out_valid←0. Not free: output held stable.
- When no channel has in_valid set, dm_x_* = channel 0 samples (don't-care); last_grant unchanged.
- Config write: cfg_n_points ∈ {4,8,12,16} → pend_val←value, cfg_busy←1. A later write while pending overwrites pend_val. Any other value → ignored, cfg_err pulses the next cycle, pending state untouched.
- Config apply: cfg_busy && out_valid==0 → dm_n_points←pend_val, cfg_busy←0. Accepts are blocked while cfg_busy is set, so no result ever mixes configurations.
- cfg_wr in the same cycle as an apply: the new value becomes pending. The apply uses the old pend_val.

## Timing
- Reset values: out_valid=0, out_index=0, out_chan=0, in_ready=0, cfg_busy=0, cfg_err=0, dm_n_points=4, last_grant=NCH-1 (channel 0 wins first), pending cleared.
- Reset mid-operation discards the held result and any pending config.
- Latency: accept in cycle N → out_valid in cycle N+1.
- Throughput: 1 result/cycle while out_ready=1.
- Fairness: with k channels continuously valid, each channel is granted once every k accepts.
- Config drain: worst case = cycles until out_ready consumes the held result, +1 cycle to apply. Accepts resume the cycle after the apply.

## Configuration
- PSK_SCHED_STATS_EN defined: adds input stat_clr (1) and output stat_count (NCH*32). Each 32-bit per-channel counter increments on every accept of that channel and saturates at 0xFFFFFFFF. stat_clr or rst zeroes all counters. If clear and accept coincide, clear wins.
- Macro undefined: these ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package psk_sched_pkg holds:
  - NP_4/NP_8/NP_12/NP_16 constants and NP_RESET = NP_4
  - the function np_legal(6-bit) returning the legality check
  - DW default
- Sub-module psk_rr_arb (parameter NCH): request vector, enable, last_grant in → one-hot grant, grant id, any-grant out. Purely combinational; last_grant state is held in the parent.

## Test plan
- Single channel: NCH=4, ch2 only valid with (256,0), out_ready=1, n_points=4 → in_ready=0100 for one cycle; next cycle out_valid=1, out_chan=2, out_index = demapper model value.
- All four channels valid continuously, out_ready=1 → grant order 0,1,2,3,0,1…; one result per cycle; no starvation over 64 accepts.
- Backpressure: out_ready=0 for 5 cycles with ch1 valid → out_valid held, out_index/out_chan stable, in_ready=0; release → transfer completes, next accept follows in the same cycle.
- Config drain: cfg_wr=8 while a result is held and out_ready=0 → cfg_busy=1, no accepts; out_ready=1 → result leaves, dm_n_points=8 one cycle later, cfg_busy=0, accepts resume.
- Illegal config: cfg_wr=7 → cfg_err pulses one cycle, dm_n_points unchanged, cfg_busy unchanged.
- Reset mid-stream with out_valid=1 and cfg_busy=1 → all outputs at reset values next cycle, and channel 0 is granted first afterwards. With PSK_SCHED_STATS_EN, counters are also zero.
